// File: rtl/regfile_pkg.sv
// Shared types and constants for the scoreboarded register file.
// Holds the sweep-clear FSM states, default sizing and a log2 helper.
package regfile_pkg;

  localparam int DEF_DATA_WIDTH = 64;
  localparam int DEF_NUM_REGS   = 32;
  localparam int DEF_READ_PORTS = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_e;

  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result = result + 1;
      v      = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: register mux, write-through bypass and
// hardwired-zero masking of data and busy.
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_REGS   = DEF_NUM_REGS,
  parameter int ZERO_REG   = NUM_REGS - 1,
  parameter int AW         = clog2(NUM_REGS)
) (
  input  logic [DATA_WIDTH-1:0] regs_i [NUM_REGS],
  input  logic [NUM_REGS-1:0]   busy_i,
  input  logic [AW-1:0]         sel_i,
  input  logic                  bypass_en_i,
  input  logic [AW-1:0]         bypass_sel_i,
  input  logic [DATA_WIDTH-1:0] bypass_data_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  busy_o
);

  logic is_zero;
  assign is_zero = (sel_i == AW'(ZERO_REG));

  // Busy never takes the bypass: it only reports registered state.
  always_comb begin
    data_o = regs_i[sel_i];
    busy_o = busy_i[sel_i];
    if (is_zero) begin
      data_o = '0;
      busy_o = 1'b0;
    end else if (bypass_en_i && (bypass_sel_i == sel_i)) begin
      data_o = bypass_data_i;
    end
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// Register file with per-register busy bits, multi-port combinational reads
// and a one-register-per-cycle sweep clear.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter  int NUM_REGS   = DEF_NUM_REGS,
  parameter  int READ_PORTS = DEF_READ_PORTS,
  parameter  int ZERO_REG   = NUM_REGS - 1,
  localparam int AW         = clog2(NUM_REGS)
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             write,
  input  logic [AW-1:0]                    dataSelect,
  input  logic [DATA_WIDTH-1:0]            dataIn,
  input  logic                             reserve,
  input  logic [AW-1:0]                    reserveSelect,
  input  logic [READ_PORTS*AW-1:0]         readSelect,
  output logic [READ_PORTS*DATA_WIDTH-1:0] readData,
  output logic [READ_PORTS-1:0]            readBusy,
  input  logic                             clearStart,
  output logic                             clearActive
);

  state_e        state_q;
  logic [AW-1:0] sweep_idx_q;
  logic          clear_active_q;

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic [NUM_REGS-1:0]   busy_bits;

  logic wr_en;
  logic rsv_en;
  logic bypass_en;

  assign bypass_en   = write && !clear_active_q;
  assign wr_en       = bypass_en && (dataSelect != AW'(ZERO_REG));
  assign rsv_en      = reserve && !clear_active_q && (reserveSelect != AW'(ZERO_REG));
  assign clearActive = clear_active_q;

  // clearStart is only looked at in IDLE, so a request during a sweep is dropped.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= IDLE;
      sweep_idx_q    <= '0;
      clear_active_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (clearStart) begin
            state_q        <= SWEEP;
            clear_active_q <= 1'b1;
            sweep_idx_q    <= '0;
          end
        end
        SWEEP: begin
          if (sweep_idx_q == AW'(NUM_REGS - 1)) begin
            state_q        <= IDLE;
            clear_active_q <= 1'b0;
            sweep_idx_q    <= '0;
          end else begin
            sweep_idx_q <= sweep_idx_q + 1'b1;
          end
        end
        default: begin
          state_q        <= IDLE;
          clear_active_q <= 1'b0;
          sweep_idx_q    <= '0;
        end
      endcase
    end
  end

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : gen_reg
    logic [DATA_WIDTH-1:0] data_q;
    logic [DATA_WIDTH-1:0] data_d;
    logic                  busy_q;
    logic                  busy_d;
    logic                  sweep_hit;
    logic                  wr_hit;
    logic                  rsv_hit;

    assign sweep_hit = clear_active_q && (sweep_idx_q == AW'(gi));
    assign wr_hit    = wr_en && (dataSelect == AW'(gi));
    assign rsv_hit   = rsv_en && (reserveSelect == AW'(gi));

    // Reserve is applied after the write so it wins on a same-register collision.
    always_comb begin
      data_d = data_q;
      busy_d = busy_q;
      if (sweep_hit) begin
        data_d = '0;
        busy_d = 1'b0;
      end else begin
        if (wr_hit) begin
          data_d = dataIn;
          busy_d = 1'b0;
        end
        if (rsv_hit) begin
          busy_d = 1'b1;
        end
      end
    end

    always_ff @(posedge clock) begin
      if (reset) begin
        data_q <= '0;
        busy_q <= 1'b0;
      end else begin
        data_q <= data_d;
        busy_q <= busy_d;
      end
    end

    assign regs[gi]      = data_q;
    assign busy_bits[gi] = busy_q;
  end

  for (genvar gi = 0; gi < READ_PORTS; gi++) begin : gen_port
    regfile_read_port #(
      .DATA_WIDTH (DATA_WIDTH),
      .NUM_REGS   (NUM_REGS),
      .ZERO_REG   (ZERO_REG),
      .AW         (AW)
    ) u_port (
      .regs_i        (regs),
      .busy_i        (busy_bits),
      .sel_i         (readSelect[gi*AW +: AW]),
      .bypass_en_i   (bypass_en),
      .bypass_sel_i  (dataSelect),
      .bypass_data_i (dataIn),
      .data_o        (readData[gi*DATA_WIDTH +: DATA_WIDTH]),
      .busy_o        (readBusy[gi])
    );
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: two configurations (64b/32 regs/2 ports and
// 16b/8 regs/3 ports) driven together and checked against a behavioural model.
module tb_regfile_scoreboard;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        rst, wr, rsv, clr;
  logic [4:0]  wsel, rsvsel;
  logic [63:0] wdata;
  logic [4:0]  rdsel [3];

  logic [9:0]   rsel0;
  logic [8:0]   rsel1;
  logic [127:0] rd0;
  logic [1:0]   rb0;
  logic         ca0;
  logic [47:0]  rd1;
  logic [2:0]   rb1;
  logic         ca1;

  assign rsel0 = {rdsel[1], rdsel[0]};
  assign rsel1 = {rdsel[2][2:0], rdsel[1][2:0], rdsel[0][2:0]};

  regfile_scoreboard #(.DATA_WIDTH(64), .NUM_REGS(32), .READ_PORTS(2)) dut0 (
    .clock(clock), .reset(rst), .write(wr), .dataSelect(wsel), .dataIn(wdata),
    .reserve(rsv), .reserveSelect(rsvsel), .readSelect(rsel0),
    .readData(rd0), .readBusy(rb0), .clearStart(clr), .clearActive(ca0)
  );

  regfile_scoreboard #(.DATA_WIDTH(16), .NUM_REGS(8), .READ_PORTS(3)) dut1 (
    .clock(clock), .reset(rst), .write(wr), .dataSelect(wsel[2:0]), .dataIn(wdata[15:0]),
    .reserve(rsv), .reserveSelect(rsvsel[2:0]), .readSelect(rsel1),
    .readData(rd1), .readBusy(rb1), .clearStart(clr), .clearActive(ca1)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [63:0] m_mem  [2][32];
  bit          m_busy [2][32];
  int          m_left [2];   // sweep cycles still to run
  int          m_pos  [2];   // next register the sweep clears
  bit          model_valid = 1'b0;

  function automatic int nregs(input int k);  return (k == 0) ? 32 : 8; endfunction
  function automatic int nports(input int k); return (k == 0) ? 2 : 3;  endfunction
  function automatic logic [63:0] dmask(input int k);
    return (k == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_0000_FFFF;
  endfunction

  always @(posedge clock) begin
    for (int k = 0; k < 2; k++) begin
      int n;
      int wa;
      int ra;
      n  = nregs(k);
      wa = int'(wsel) % n;
      ra = int'(rsvsel) % n;
      if (rst) begin
        for (int r = 0; r < 32; r++) begin
          m_mem[k][r]  = '0;
          m_busy[k][r] = 1'b0;
        end
        m_left[k] = 0;
        m_pos[k]  = 0;
      end else if (m_left[k] > 0) begin
        m_mem[k][m_pos[k]]  = '0;
        m_busy[k][m_pos[k]] = 1'b0;
        m_pos[k]++;
        m_left[k]--;
      end else begin
        if (wr && wa != n - 1) begin
          m_mem[k][wa]  = wdata & dmask(k);
          m_busy[k][wa] = 1'b0;
        end
        if (rsv && ra != n - 1) m_busy[k][ra] = 1'b1;
        if (clr) begin
          m_left[k] = n;
          m_pos[k]  = 0;
        end
      end
    end
    if (rst) model_valid = 1'b1;
  end

  function automatic logic [63:0] act_data(input int k, input int p);
    if (k == 0) return rd0[p*64 +: 64];
    return {48'b0, rd1[p*16 +: 16]};
  endfunction

  function automatic logic act_busy(input int k, input int p);
    if (k == 0) return rb0[p];
    return rb1[p];
  endfunction

  always @(negedge clock) begin
    if (model_valid) begin
      for (int k = 0; k < 2; k++) begin
        int n;
        bit active;
        n      = nregs(k);
        active = (m_left[k] > 0);
        chk($sformatf("model dut%0d.clearActive", k), {63'b0, (k == 0) ? ca0 : ca1}, {63'b0, active});
        for (int p = 0; p < nports(k); p++) begin
          int s;
          logic [63:0] ed;
          logic eb;
          s = int'(rdsel[p]) % n;
          if (s == n - 1) begin
            ed = '0;
            eb = 1'b0;
          end else begin
            ed = m_mem[k][s];
            eb = m_busy[k][s];
            if (wr && !active && (int'(wsel) % n) == s) ed = wdata & dmask(k);
          end
          chk($sformatf("model dut%0d.port%0d.data r%0d", k, p, s), act_data(k, p), ed);
          chk($sformatf("model dut%0d.port%0d.busy r%0d", k, p, s), {63'b0, act_busy(k, p)}, {63'b0, eb});
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    wr = 1'b0; rsv = 1'b0; clr = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic fill(input int lo, input int hi);
    for (int r = lo; r <= hi; r++) begin
      wr = 1'b1; wsel = 5'(r);
      wdata = {32'(r) + 32'h100, 32'hCAFE_0000 | 32'(r)};
      rsv = r[0]; rsvsel = 5'(r);
      tick();
    end
    idle_inputs();
  endtask

  task automatic scan_zero(input string tag);
    for (int r = 0; r < 32; r++) begin
      rdsel[0] = 5'(r);
      #1;
      chk($sformatf("%s dut0 r%0d data", tag, r), act_data(0, 0), 64'h0);
      chk($sformatf("%s dut0 r%0d busy", tag, r), {63'b0, rb0[0]}, 64'h0);
      if (r < 8) begin
        chk($sformatf("%s dut1 r%0d data", tag, r), act_data(1, 0), 64'h0);
        chk($sformatf("%s dut1 r%0d busy", tag, r), {63'b0, rb1[0]}, 64'h0);
      end
    end
  endtask

  initial begin
    int cnt0;
    int cnt1;
    rst = 1'b1; wr = 1'b0; rsv = 1'b0; clr = 1'b0;
    wsel = '0; rsvsel = '0; wdata = '0;
    for (int p = 0; p < 3; p++) rdsel[p] = '0;
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("reset ca0", {63'b0, ca0}, 64'h0);
    chk("reset ca1", {63'b0, ca1}, 64'h0);
    chk("reset rd0", rd0[63:0], 64'h0);
    chk("reset rb1", {61'b0, rb1}, 64'h0);

    // write then read next cycle
    wr = 1'b1; wsel = 5'd3; wdata = 64'hDEAD_BEEF_0000_0001;
    tick();
    wr = 1'b0; rdsel[0] = 5'd3;
    #1;
    chk("r3 readback dut0", act_data(0, 0), 64'hDEAD_BEEF_0000_0001);
    chk("r3 busy dut0", {63'b0, rb0[0]}, 64'h0);
    chk("r3 readback dut1", act_data(1, 0), 64'h0001);

    // same-cycle bypass, and zero register ignores writes
    wr = 1'b1; wsel = 5'd5; wdata = 64'h1234; rdsel[0] = 5'd5;
    #1;
    chk("r5 bypass dut0", act_data(0, 0), 64'h1234);
    chk("r5 bypass dut1", act_data(1, 0), 64'h1234);
    tick();
    wsel = 5'd31; wdata = 64'hFFFF; rdsel[1] = 5'd31;
    #1;
    chk("zero reg no bypass", act_data(0, 1), 64'h0);
    tick();
    wr = 1'b0;
    #1;
    chk("zero reg after write", act_data(0, 1), 64'h0);

    // reserve / write interplay
    rsv = 1'b1; rsvsel = 5'd7;
    tick();
    rsv = 1'b0; rdsel[0] = 5'd7;
    #1;
    chk("r7 busy after reserve", {63'b0, rb0[0]}, 64'h1);
    chk("dut1 zero reg never busy", {63'b0, rb1[0]}, 64'h0);
    wr = 1'b1; wsel = 5'd7; wdata = 64'h77;
    tick();
    wr = 1'b0;
    #1;
    chk("r7 busy cleared by write", {63'b0, rb0[0]}, 64'h0);
    wr = 1'b1; rsv = 1'b1; wsel = 5'd9; rsvsel = 5'd9; wdata = 64'hABCD;
    tick();
    idle_inputs(); rdsel[0] = 5'd9;
    #1;
    chk("r9 reserve wins busy", {63'b0, rb0[0]}, 64'h1);
    chk("r9 data updated", act_data(0, 0), 64'hABCD);
    chk("dut1 r1 reserve wins", {63'b0, rb1[0]}, 64'h1);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      rst   = ($urandom_range(0, 199) == 0);
      wr    = 1'($urandom_range(0, 1));
      wsel  = 5'($urandom_range(0, 31));
      wdata = {$urandom, $urandom};
      rsv   = ($urandom_range(0, 2) == 0);
      rsvsel = 5'($urandom_range(0, 31));
      clr   = ($urandom_range(0, 29) == 0);
      for (int p = 0; p < 3; p++)
        rdsel[p] = ($urandom_range(0, 1) == 0) ? wsel : 5'($urandom_range(0, 31));
      tick();
    end
    rst = 1'b0;

    // full fill, then sweep with a write dropped mid-sweep
    do_reset();
    fill(0, 31);
    rdsel[0] = 5'd10; rdsel[1] = 5'd11;
    #1;
    chk("fill r10 data", act_data(0, 0), {32'h10A, 32'hCAFE_000A});
    chk("fill r10 busy", {63'b0, rb0[0]}, 64'h0);
    chk("fill r11 busy", {63'b0, rb0[1]}, 64'h1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    cnt0 = 0;
    cnt1 = 0;
    for (int i = 0; i < 40; i++) begin
      if (ca0) cnt0++;
      if (ca1) cnt1++;
      if (i == 4) begin
        wr = 1'b1; wsel = 5'd2; wdata = 64'h5555_5555_5555_5555;
      end else begin
        wr = 1'b0;
      end
      tick();
    end
    chk("sweep length dut0", 64'(cnt0), 64'd32);
    chk("sweep length dut1", 64'(cnt1), 64'd8);
    scan_zero("after sweep");

    // reset aborts a sweep in progress
    fill(20, 31);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    repeat (10) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("abort ca0", {63'b0, ca0}, 64'h0);
    chk("abort ca1", {63'b0, ca1}, 64'h0);
    scan_zero("after abort");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_scoreboard.md
REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 Parameter DATA_WIDTH, default 64, SHALL set the register data width.
REQ-002 Parameter NUM_REGS, default 32, SHALL set the register count, with a minimum of 2 and a power of two.
REQ-003 Parameter READ_PORTS, default 2, SHALL set the number of independent read ports, range 1..4.
REQ-004 Parameter ZERO_REG, default NUM_REGS-1, SHALL set the index of the hardwired-zero register.
REQ-005 Localparam AW SHALL equal clog2(NUM_REGS).
REQ-006 The port list SHALL be as follows, clock and reset first:
- clock  in  1  sole clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high.
- write  in  1  write enable.
- dataSelect  in  AW  write address.
- dataIn  in  DATA_WIDTH  write data.
- reserve  in  1  marks a register pending (busy).
- reserveSelect  in  AW  reserve address.
- readSelect  in  READ_PORTS*AW  flattened read addresses; port p uses bits [p*AW +: AW].
- readData  out  READ_PORTS*DATA_WIDTH  flattened read data.
- readBusy  out  READ_PORTS  busy bit of each addressed register.
- clearStart  in  1  one-cycle request to start a sweep-clear.
- clearActive  out  1  high while the sweep is running.

Function
REQ-007 Storage SHALL be NUM_REGS x DATA_WIDTH data plus one busy bit per register.
REQ-008 Reads SHALL be combinational, with zero-cycle latency.
- If write=1, dataSelect equals that port's readSelect, the address is not ZERO_REG and clearActive=0, readData SHALL return dataIn (write-through bypass).
- Otherwise readData SHALL return the stored value.
REQ-009 A write with write=1 SHALL update dataSelect at the edge and clear its busy bit.
REQ-010 reserve=1 SHALL set the busy bit of reserveSelect at the edge.
REQ-011 If write and reserve target the same register in one cycle, the data SHALL update and the busy bit SHALL end at 1 (reserve wins).
REQ-012 A write to a non-busy register SHALL be legal and SHALL leave busy at 0.
REQ-013 ZERO_REG handling:
- Reads SHALL return 0 and readBusy SHALL be 0.
- Writes and reserves to it SHALL be ignored.
- Bypass SHALL never apply to it.
REQ-014 readBusy SHALL reflect registered busy state only; there SHALL be no same-cycle bypass of reserve or write into readBusy.
REQ-015 The FSM SHALL have two states, IDLE and SWEEP.
- IDLE->SWEEP when clearStart=1.
- SWEEP->IDLE after the sweep index reaches NUM_REGS-1.
REQ-016 In SWEEP, each cycle SHALL zero the data and busy bit of register index, then increment index.
- The sweep SHALL start at 0, so a full clear takes exactly NUM_REGS cycles.
- clearActive SHALL be high for exactly those NUM_REGS cycles.
REQ-017 While clearActive=1:
- write and reserve SHALL be ignored.
- clearStart SHALL be ignored.
- Reads SHALL return current stored contents, with no bypass.
REQ-018 clearStart asserted in the same cycle as write or reserve SHALL let that write or reserve take effect, and the sweep SHALL begin on the next cycle.

Reset
REQ-019 reset=1 at a rising edge SHALL zero all data and busy bits, force IDLE, zero the sweep index and drive clearActive=0.
REQ-020 reset SHALL take priority over all other inputs.
REQ-021 reset asserted mid-sweep SHALL abort the sweep.
REQ-022 After reset, every readData SHALL be 0 and every readBusy SHALL be 0.

Structure
REQ-023 Package regfile_pkg SHALL hold:
- the FSM state enum (IDLE, SWEEP).
- default parameter constants (64, 32, 2).
- a clog2 helper function.
REQ-024 Sub-module regfile_read_port, containing the read mux, bypass and ZERO_REG masking, SHALL be instantiated READ_PORTS times via generate.
REQ-025 No other sub-modules SHALL be used.

Verification
REQ-026 Write 0xDEADBEEF_00000001 to r3, then read r3 next cycle -> readData=0xDEADBEEF_00000001, readBusy=0.
REQ-027 Port 0 reads r5 while writing 0x1234 to r5 in the same cycle -> readData=0x1234 that cycle; a ZERO_REG write of 0xFFFF -> reads 0.
REQ-028 Reserve r7, then read r7 next cycle -> busy=1; write r7 -> busy=0 next cycle. Reserve and write r9 in the same cycle -> busy=1, data updated.
REQ-029 Fill all registers, pulse clearStart -> clearActive high for 32 cycles; a write issued mid-sweep is dropped; afterwards all reads are 0 and all readBusy are 0.
REQ-030 Assert reset at sweep cycle 10 -> clearActive=0 next cycle and all state is zero.
REQ-031 Re-run REQ-026..REQ-029 with DATA_WIDTH=16, NUM_REGS=8, READ_PORTS=3 -> identical behaviour, sweep length 8.
